// File: rtl/serial_add_controller_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: wide enough to hold WIDTH itself so it never wraps.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_controller_adder.sv
// 1-bit full-adder cell used by the serial adder controller.
module serial_add_controller_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  // Combinational full-add of one bit position.
  always_comb begin
    sum   = a ^ b ^ c_in;
    c_out = (a & b) | (c_in & (a ^ b));
  end

endmodule

// File: rtl/serial_add_controller.sv
// Bit-serial adder: one full-adder cell sequenced LSB-first, one bit per clock.
// Upstream valid/ready operand port, downstream valid/ack result port.
module serial_add_controller
  import serial_add_controller_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_augend,
  input  logic [WIDTH-1:0] i_addend,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int unsigned     CW   = count_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH:0]   sum_shift;
  logic             carry;
  logic             carry_out;
  logic [CW-1:0]    count;
  logic             cell_sum;
  logic             cell_carry;
  logic             last_bit;

  serial_add_controller_adder u_adder (
    .a     (a_reg[0]),
    .b     (b_reg[0]),
    .c_in  (carry),
    .sum   (cell_sum),
    .c_out (cell_carry)
  );

  // New sum bit enters at the MSB; written via a wide vector so WIDTH=1 needs no special case.
  assign sum_shift = {cell_sum, sum_reg};
  assign last_bit  = (state == ST_RUN) && (count == LAST);

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (i_valid)  state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: if (i_ack)    state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // Handshake and result outputs.
  always_comb begin
    o_ready = (state == ST_IDLE);
    o_valid = (state == ST_DONE);
    o_sum   = sum_reg;
    o_carry = carry_out;
  end

  // Operand/result shift registers, carry flop and bit counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      count     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_valid) begin
            a_reg <= i_augend;
            b_reg <= i_addend;
            carry <= i_carry;
            count <= '0;
          end
        end
        ST_RUN: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          sum_reg <= sum_shift[WIDTH:1];
          carry   <= cell_carry;
          count   <= count + CW'(1);
          if (last_bit) carry_out <= cell_carry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_controller.sv
// Self-checking bench for serial_add_controller at WIDTH = 8, 1 and 16.
module tb_serial_add_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v8, ack8, c8, rdy8, val8, co8;
  logic [7:0]  a8, b8, sum8;
  logic        v1, ack1, c1, rdy1, val1, co1;
  logic [0:0]  a1, b1, sum1;
  logic        v16, ack16, c16, rdy16, val16, co16;
  logic [15:0] a16, b16, sum16;

  int vectors     = 0;
  int miscompares = 0;

  serial_add_controller #(.WIDTH(8)) dut8 (
    .i_clock(clk), .i_reset(rst), .i_valid(v8), .o_ready(rdy8),
    .i_augend(a8), .i_addend(b8), .i_carry(c8), .o_valid(val8),
    .i_ack(ack8), .o_sum(sum8), .o_carry(co8)
  );

  serial_add_controller #(.WIDTH(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_valid(v1), .o_ready(rdy1),
    .i_augend(a1), .i_addend(b1), .i_carry(c1), .o_valid(val1),
    .i_ack(ack1), .o_sum(sum1), .o_carry(co1)
  );

  serial_add_controller #(.WIDTH(16)) dut16 (
    .i_clock(clk), .i_reset(rst), .i_valid(v16), .o_ready(rdy16),
    .i_augend(a16), .i_addend(b16), .i_carry(c16), .o_valid(val16),
    .i_ack(ack16), .o_sum(sum16), .o_carry(co16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, split at bit w.
  function automatic int unsigned ref_sum(input int unsigned a, b, cin, w);
    return (a + b + cin) % (32'd1 << w);
  endfunction

  function automatic int unsigned ref_carry(input int unsigned a, b, cin, w);
    return (a + b + cin) >> w;
  endfunction

  task automatic job8(input int unsigned a, b, cin, hold, input string tag);
    int n;
    logic [7:0] held_sum;
    logic       held_co;
    @(negedge clk);
    v8 = 1'b1; a8 = 8'(a); b8 = 8'(b); c8 = 1'(cin);
    check({tag, "/ready_before"}, 32'(rdy8), 1);
    @(negedge clk);
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    n = 0;
    while (!val8 && n < 40) begin @(negedge clk); n++; end
    check({tag, "/latency"}, n, 8);
    check({tag, "/sum"},   32'(sum8), ref_sum(a, b, cin, 8));
    check({tag, "/carry"}, 32'(co8),  ref_carry(a, b, cin, 8));
    held_sum = sum8; held_co = co8;
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(val8), 1);
      check({tag, "/hold_sum"},   32'(sum8), 32'(held_sum));
      check({tag, "/hold_carry"}, 32'(co8),  32'(held_co));
    end
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    check({tag, "/valid_after_ack"}, 32'(val8), 0);
    check({tag, "/ready_after_ack"}, 32'(rdy8), 1);
    check({tag, "/sum_retained"},    32'(sum8), ref_sum(a, b, cin, 8));
  endtask

  task automatic job1(input int unsigned a, b, cin, input string tag);
    int n;
    @(negedge clk);
    v1 = 1'b1; a1 = 1'(a); b1 = 1'(b); c1 = 1'(cin);
    @(negedge clk);
    v1 = 1'b0;
    n = 0;
    while (!val1 && n < 10) begin @(negedge clk); n++; end
    check({tag, "/latency"}, n, 1);
    check({tag, "/sum"},   32'(sum1), ref_sum(a, b, cin, 1));
    check({tag, "/carry"}, 32'(co1),  ref_carry(a, b, cin, 1));
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    check({tag, "/ready_after_ack"}, 32'(rdy1), 1);
  endtask

  // Random job: garbage on i_valid/operands and stray i_ack while busy must be ignored.
  task automatic job16(input int unsigned a, b, cin, ack_delay);
    int n;
    @(negedge clk);
    v16 = 1'b1; a16 = 16'(a); b16 = 16'(b); c16 = 1'(cin);
    @(negedge clk);
    n = 0;
    while (!val16 && n < 60) begin
      v16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      ack16 = 1'($urandom);
      @(negedge clk);
      n++;
    end
    v16 = 1'b0; ack16 = 1'b0;
    check("w16/latency", n, 16);
    check("w16/sum",   32'(sum16), ref_sum(a, b, cin, 16));
    check("w16/carry", 32'(co16),  ref_carry(a, b, cin, 16));
    check("w16/ready_in_done", 32'(rdy16), 0);
    repeat (ack_delay) @(negedge clk);
    ack16 = 1'b1;
    @(negedge clk);
    ack16 = 1'b0;
    check("w16/ready_after_ack", 32'(rdy16), 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    v8 = 0; ack8 = 0; c8 = 0; a8 = '0; b8 = '0;
    v1 = 0; ack1 = 0; c1 = 0; a1 = '0; b1 = '0;
    v16 = 0; ack16 = 0; c16 = 0; a16 = '0; b16 = '0;

    // 1: reset
    repeat (2) @(negedge clk);
    check("reset/ready8", 32'(rdy8), 1);
    check("reset/valid8", 32'(val8), 0);
    check("reset/sum8",   32'(sum8), 0);
    check("reset/carry8", 32'(co8),  0);
    check("reset/ready1", 32'(rdy1), 1);
    check("reset/ready16", 32'(rdy16), 1);
    check("reset/valid16", 32'(val16), 0);
    rst = 1'b0;

    // 2: basic add with 5-cycle hold
    job8('h3C, 'h0F, 0, 5, "add_3c_0f");

    // 3: overflow cases
    job8('hFF, 'h01, 0, 0, "ovf_ff_01");
    job8('hFF, 'hFF, 1, 0, "ovf_ff_ff_c");

    // 4: busy protection and ack/valid coincidence
    @(negedge clk);
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h55;
    n = 0;
    while (!val8 && n < 40) begin
      check("busy/ready_run", 32'(rdy8), 0);
      @(negedge clk);
      n++;
    end
    check("busy/latency", n, 8);
    check("busy/sum", 32'(sum8), 'h02);
    check("busy/carry", 32'(co8), 0);
    repeat (2) begin
      @(negedge clk);
      check("busy/ready_done", 32'(rdy8), 0);
      check("busy/sum_done", 32'(sum8), 'h02);
    end
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    check("busy/idle_after_ack", 32'(rdy8), 1);
    check("busy/valid_after_ack", 32'(val8), 0);
    @(negedge clk);
    v8 = 1'b0;
    check("busy/second_accepted", 32'(rdy8), 0);
    n = 0;
    while (!val8 && n < 40) begin @(negedge clk); n++; end
    check("busy/second_latency", n, 8);
    check("busy/second_sum", 32'(sum8), 'hAA);
    check("busy/second_carry", 32'(co8), 0);
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;

    // 5: reset in the 4th RUN cycle
    @(negedge clk);
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst/ready", 32'(rdy8), 1);
    check("midrst/valid", 32'(val8), 0);
    check("midrst/sum",   32'(sum8), 0);
    check("midrst/carry", 32'(co8),  0);
    @(negedge clk);
    check("midrst/still_idle", 32'(val8), 0);
    job8('h10, 'h20, 0, 0, "after_rst");

    // 6a: WIDTH=1 truth table
    for (int i = 0; i < 8; i++) job1(i & 1, (i >> 1) & 1, (i >> 2) & 1, "w1");

    // 6b: WIDTH=16 random regression
    for (int j = 0; j < 1000; j++)
      job16($urandom & 32'hFFFF, $urandom & 32'hFFFF, $urandom & 1, $urandom_range(0, 3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
